// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register of a 5-stage MIPS pipeline: operand
// forwarding, ALU control and ALU, branch-target adder and an iterative HI/LO multiplier.
module ex_mem_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] X_PCplusFour,
    input  logic [31:0] X_readData1,
    input  logic [31:0] X_readData2,
    input  logic [31:0] X_signExtend,
    input  logic [4:0]  X_rt,
    input  logic [4:0]  X_rd,
    input  logic [5:0]  X_funct,
    input  logic [1:0]  X_WB,
    input  logic [2:0]  X_M,
    input  logic [3:0]  X_EX,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] W_writeData,
    output logic        exStall,
    output logic [1:0]  M_WB,
    output logic [2:0]  M_M,
    output logic [31:0] M_branchTarget,
    output logic        M_zero,
    output logic [31:0] M_ALUresult,
    output logic [31:0] M_writeData,
    output logic [4:0]  M_writeReg
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_NOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_MFHI  = 4'd6,
        ALU_MFLO  = 4'd7,
        ALU_MULT  = 4'd8,
        ALU_MULTU = 4'd9,
        ALU_ZERO  = 4'd10
    } alu_ctrl_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);

    // Decoded ID/EX control fields
    logic        reg_dst_s;
    logic [1:0]  alu_op_s;
    logic        alu_src_s;

    // Datapath
    logic [31:0] op_a_s;
    logic [31:0] op_bf_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_res_s;
    logic [31:0] branch_target_s;
    alu_ctrl_t   alu_ctrl_s;
    logic        is_mul_s;
    logic        is_hilo_s;

    // Multiplier state
    mul_state_t  mul_state_r;
    logic [5:0]  mul_cnt_r;
    logic [63:0] mul_prod_r;
    logic [31:0] mul_mcand_r;
    logic        mul_neg_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] mul_next_s;

    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] mem_val,
        input logic [31:0] wb_val
    );
        logic [31:0] res;
        case (sel)
            2'b10:   res = mem_val;
            2'b01:   res = wb_val;
            2'b00:   res = reg_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] val, input logic is_signed);
        logic [31:0] res;
        if (is_signed && val[31]) begin
            res = 32'd0 - val;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // One radix-2 shift-add step: upper half accumulates the multiplicand while the
    // multiplier bits shift out of the lower half.
    function automatic logic [63:0] mul_step(input logic [63:0] prod, input logic [31:0] mcand);
        logic [32:0] upper;
        if (prod[0]) begin
            upper = {1'b0, prod[63:32]} + {1'b0, mcand};
        end else begin
            upper = {1'b0, prod[63:32]};
        end
        return {upper, prod[31:1]};
    endfunction

    assign reg_dst_s       = X_EX[3];
    assign alu_op_s        = X_EX[2:1];
    assign alu_src_s       = X_EX[0];
    assign op_a_s          = fwd_mux(ForwardA, X_readData1, M_ALUresult, W_writeData);
    assign op_bf_s         = fwd_mux(ForwardB, X_readData2, M_ALUresult, W_writeData);
    assign alu_b_s         = alu_src_s ? X_signExtend : op_bf_s;
    assign branch_target_s = X_PCplusFour + {X_signExtend[29:0], 2'b00};
    assign is_mul_s        = (alu_ctrl_s == ALU_MULT) || (alu_ctrl_s == ALU_MULTU);
    assign is_hilo_s       = is_mul_s || (alu_ctrl_s == ALU_MFHI) || (alu_ctrl_s == ALU_MFLO);
    assign exStall         = (mul_state_r == MUL_BUSY) && is_hilo_s;
    assign mul_next_s      = mul_step(mul_prod_r, mul_mcand_r);

    // ALU control: ALUop plus funct field to an ALU operation
    always_comb begin
        alu_ctrl_s = ALU_ZERO;
        case (alu_op_s)
            2'b00: alu_ctrl_s = ALU_ADD;
            2'b01: alu_ctrl_s = ALU_SUB;
            2'b10: begin
                case (X_funct)
                    FN_ADD:   alu_ctrl_s = ALU_ADD;
                    FN_SUB:   alu_ctrl_s = ALU_SUB;
                    FN_AND:   alu_ctrl_s = ALU_AND;
                    FN_OR:    alu_ctrl_s = ALU_OR;
                    FN_NOR:   alu_ctrl_s = ALU_NOR;
                    FN_SLT:   alu_ctrl_s = ALU_SLT;
                    FN_MFHI:  alu_ctrl_s = ALU_MFHI;
                    FN_MFLO:  alu_ctrl_s = ALU_MFLO;
                    FN_MULT:  alu_ctrl_s = ALU_MULT;
                    FN_MULTU: alu_ctrl_s = ALU_MULTU;
                    default:  alu_ctrl_s = ALU_ZERO;
                endcase
            end
            default: alu_ctrl_s = ALU_ZERO;
        endcase
    end

    // ALU result selection; multiply issue itself produces no register result
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_ctrl_s)
            ALU_ADD:  alu_res_s = op_a_s + alu_b_s;
            ALU_SUB:  alu_res_s = op_a_s - alu_b_s;
            ALU_AND:  alu_res_s = op_a_s & alu_b_s;
            ALU_OR:   alu_res_s = op_a_s | alu_b_s;
            ALU_NOR:  alu_res_s = ~(op_a_s | alu_b_s);
            ALU_SLT: begin
                if ($signed(op_a_s) < $signed(alu_b_s)) begin
                    alu_res_s = 32'd1;
                end else begin
                    alu_res_s = 32'd0;
                end
            end
            ALU_MFHI: alu_res_s = hi_r;
            ALU_MFLO: alu_res_s = lo_r;
            default:  alu_res_s = 32'd0;
        endcase
    end

    // Multiplier FSM: sign-magnitude shift-add, one bit per cycle, sign applied on the final edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mul_state_r <= MUL_IDLE;
            mul_cnt_r   <= 6'd0;
            mul_prod_r  <= 64'd0;
            mul_mcand_r <= 32'd0;
            mul_neg_r   <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
        end else begin
            case (mul_state_r)
                MUL_IDLE: begin
                    if (is_mul_s) begin
                        mul_state_r <= MUL_BUSY;
                        mul_cnt_r   <= MUL_LOAD;
                        mul_mcand_r <= magnitude(op_a_s, alu_ctrl_s == ALU_MULT);
                        mul_prod_r  <= {32'd0, magnitude(op_bf_s, alu_ctrl_s == ALU_MULT)};
                        mul_neg_r   <= (alu_ctrl_s == ALU_MULT) && (op_a_s[31] ^ op_bf_s[31]);
                    end
                end
                MUL_BUSY: begin
                    mul_cnt_r <= mul_cnt_r - 6'd1;
                    if (mul_cnt_r == 6'd1) begin
                        mul_state_r <= MUL_IDLE;
                        if (mul_neg_r) begin
                            {hi_r, lo_r} <= 64'd0 - mul_next_s;
                        end else begin
                            {hi_r, lo_r} <= mul_next_s;
                        end
                    end else begin
                        mul_prod_r <= mul_next_s;
                    end
                end
                default: begin
                    mul_state_r <= MUL_IDLE;
                    mul_cnt_r   <= 6'd0;
                end
            endcase
        end
    end

    // EX/MEM pipeline register; a stall inserts an all-zero bubble
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            M_WB           <= 2'b00;
            M_M            <= 3'b000;
            M_branchTarget <= 32'd0;
            M_zero         <= 1'b0;
            M_ALUresult    <= 32'd0;
            M_writeData    <= 32'd0;
            M_writeReg     <= 5'd0;
        end else if (exStall) begin
            M_WB           <= 2'b00;
            M_M            <= 3'b000;
            M_branchTarget <= 32'd0;
            M_zero         <= 1'b0;
            M_ALUresult    <= 32'd0;
            M_writeData    <= 32'd0;
            M_writeReg     <= 5'd0;
        end else begin
            M_WB           <= is_mul_s ? 2'b00 : X_WB;
            M_M            <= is_mul_s ? 3'b000 : X_M;
            M_branchTarget <= branch_target_s;
            M_zero         <= (alu_res_s == 32'd0);
            M_ALUresult    <= alu_res_s;
            M_writeData    <= op_bf_s;
            M_writeReg     <= reg_dst_s ? X_rd : X_rt;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: ALU ops, forwarding, branch target,
// MULT/MULTU with stall counting, and reset in the middle of a multiply.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] X_PCplusFour, X_readData1, X_readData2, X_signExtend;
    logic [4:0]  X_rt, X_rd;
    logic [5:0]  X_funct;
    logic [1:0]  X_WB;
    logic [2:0]  X_M;
    logic [3:0]  X_EX;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] W_writeData;
    logic        exStall;
    logic [1:0]  M_WB;
    logic [2:0]  M_M;
    logic [31:0] M_branchTarget;
    logic        M_zero;
    logic [31:0] M_ALUresult;
    logic [31:0] M_writeData;
    logic [4:0]  M_writeReg;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stall;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR  = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                           F_MULT = 6'b011000, F_MULTU = 6'b011001;

    ex_mem_stage #(.MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .X_PCplusFour(X_PCplusFour), .X_readData1(X_readData1), .X_readData2(X_readData2),
        .X_signExtend(X_signExtend), .X_rt(X_rt), .X_rd(X_rd), .X_funct(X_funct),
        .X_WB(X_WB), .X_M(X_M), .X_EX(X_EX), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .W_writeData(W_writeData), .exStall(exStall), .M_WB(M_WB), .M_M(M_M),
        .M_branchTarget(M_branchTarget), .M_zero(M_zero), .M_ALUresult(M_ALUresult),
        .M_writeData(M_writeData), .M_writeReg(M_writeReg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic r_type(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        X_EX = 4'b1100; X_WB = 2'b01; X_M = 3'b000; X_funct = fn;
        X_readData1 = a; X_readData2 = b; X_rd = rd; X_rt = 5'd9;
        X_signExtend = 32'd0; X_PCplusFour = 32'd0;
        ForwardA = 2'b00; ForwardB = 2'b00; W_writeData = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb"},    64'(M_WB), 64'd0);
        check({tag, "_m"},     64'(M_M), 64'd0);
        check({tag, "_bt"},    64'(M_branchTarget), 64'd0);
        check({tag, "_zero"},  64'(M_zero), 64'd0);
        check({tag, "_res"},   64'(M_ALUresult), 64'd0);
        check({tag, "_wd"},    64'(M_writeData), 64'd0);
        check({tag, "_wr"},    64'(M_writeReg), 64'd0);
        check({tag, "_stall"}, 64'(exStall), 64'd0);
    endtask

    // Count stalled edges of the instruction currently in EX, bounded
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!exStall) break;
            n++;
            cyc();
            if (n == 1) check("stall_bubble_wb", 64'(M_WB), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        r_type(6'b000000, 32'd0, 32'd0, 5'd0);
        X_EX = 4'b0000; X_WB = 2'b00;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        rst = 1'b0;

        r_type(F_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5);
        cyc();
        check("add_res", 64'(M_ALUresult), 64'h8000_0000);
        check("add_wr",  64'(M_writeReg), 64'd5);
        check("add_zero", 64'(M_zero), 64'd0);
        check("add_wb",  64'(M_WB), 64'b01);

        r_type(F_SUB, 32'd7, 32'd7, 5'd6);
        cyc();
        check("sub_res",  64'(M_ALUresult), 64'd0);
        check("sub_zero", 64'(M_zero), 64'd1);

        r_type(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd7);
        cyc();
        check("slt_res", 64'(M_ALUresult), 64'd1);

        r_type(F_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd1);
        cyc();
        check("and_res", 64'(M_ALUresult), 64'h0000_F000);
        r_type(F_OR, 32'h0000_F0F0, 32'h0000_FF00, 5'd1);
        cyc();
        check("or_res", 64'(M_ALUresult), 64'h0000_FFF0);
        r_type(F_NOR, 32'd0, 32'd0, 5'd1);
        cyc();
        check("nor_res", 64'(M_ALUresult), 64'hFFFF_FFFF);
        r_type(6'b111111, 32'd5, 32'd6, 5'd1);
        cyc();
        check("badfn_res", 64'(M_ALUresult), 64'd0);
        r_type(F_ADD, 32'd5, 32'd6, 5'd1);
        X_EX = 4'b1110;
        cyc();
        check("op11_res", 64'(M_ALUresult), 64'd0);

        // Forwarding into a store: A from EX/MEM, B from write-back
        r_type(F_ADD, 32'h0000_1000, 32'h0000_0234, 5'd3);
        cyc();
        check("fwd_prev", 64'(M_ALUresult), 64'h1234);
        X_EX = 4'b0001; X_WB = 2'b00; X_M = 3'b001; X_funct = 6'b000000;
        X_readData1 = 32'hDEAD_0000; X_readData2 = 32'h55; X_signExtend = 32'd4;
        ForwardA = 2'b10; ForwardB = 2'b01; W_writeData = 32'h0000_ABCD; X_rt = 5'd7;
        cyc();
        check("sw_res", 64'(M_ALUresult), 64'h1238);
        check("sw_wd",  64'(M_writeData), 64'hABCD);
        check("sw_m",   64'(M_M), 64'b001);
        check("sw_wr",  64'(M_writeReg), 64'd7);

        r_type(6'b000000, 32'h55, 32'h55, 5'd0);
        X_EX = 4'b0010; X_WB = 2'b00; X_M = 3'b100;
        X_PCplusFour = 32'h100; X_signExtend = 32'hFFFF_FFFF;
        cyc();
        check("beq_bt",   64'(M_branchTarget), 64'hFC);
        check("beq_m",    64'(M_M), 64'b100);
        check("beq_zero", 64'(M_zero), 64'd1);

        // Signed multiply followed immediately by MFHI, then MFLO
        r_type(F_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
        #1;
        check("mult_nostall", 64'(exStall), 64'd0);
        cyc();
        check("mult_wb", 64'(M_WB), 64'd0);
        check("mult_m",  64'(M_M), 64'd0);
        r_type(F_MFHI, 32'd0, 32'd0, 5'd8);
        count_stalls(n_stall);
        check("mfhi_stalls", 64'(n_stall), 64'd32);
        cyc();
        check("mfhi_res", 64'(M_ALUresult), 64'hFFFF_FFFF);
        check("mfhi_wb",  64'(M_WB), 64'b01);
        check("mfhi_wr",  64'(M_writeReg), 64'd8);
        r_type(F_MFLO, 32'd0, 32'd0, 5'd9);
        #1;
        check("mflo_nostall", 64'(exStall), 64'd0);
        cyc();
        check("mflo_res", 64'(M_ALUresult), 64'hFFFF_FFFA);

        // Unsigned multiply with an independent add in its shadow
        r_type(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        cyc();
        check("multu_wb", 64'(M_WB), 64'd0);
        r_type(F_ADD, 32'd2, 32'd3, 5'd4);
        #1;
        check("shadow_nostall", 64'(exStall), 64'd0);
        cyc();
        check("shadow_res", 64'(M_ALUresult), 64'd5);
        check("shadow_wb",  64'(M_WB), 64'b01);
        r_type(F_MFHI, 32'd0, 32'd0, 5'd8);
        count_stalls(n_stall);
        check("multu_stalls", 64'(n_stall), 64'd31);
        cyc();
        check("multu_hi", 64'(M_ALUresult), 64'hFFFF_FFFE);
        r_type(F_MFLO, 32'd0, 32'd0, 5'd9);
        cyc();
        check("multu_lo", 64'(M_ALUresult), 64'h0000_0001);

        // Reset ten cycles into a multiply must clear HI/LO
        r_type(F_MULT, 32'd5, 32'd7, 5'd0);
        cyc();
        r_type(F_MFHI, 32'd0, 32'd0, 5'd8);
        repeat (10) cyc();
        check("mid_busy", 64'(exStall), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        rst = 1'b0;
        #1;
        cyc();
        check("rst_mfhi_res", 64'(M_ALUresult), 64'd0);
        check("rst_mfhi_wb",  64'(M_WB), 64'b01);
        r_type(F_MFLO, 32'd0, 32'd0, 5'd9);
        cyc();
        check("rst_mflo_res", 64'(M_ALUresult), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
